// File: rtl/csr_gpio_pkg.sv
// rtl/csr_gpio_pkg.sv - shared CSR op encoding, default GPIO addresses and op helper
package csr_gpio_pkg;

    typedef enum logic [1:0] {
        CSR_WRITE = 2'd0,
        CSR_SET   = 2'd1,
        CSR_CLEAR = 2'd2,
        CSR_RSVD  = 2'd3
    } csr_op_e;

    localparam logic [11:0] GPIO_IN_BASE   = 12'hF00;
    localparam logic [11:0] GPIO_OUT_BASE  = 12'hF02;
    localparam logic [11:0] GPIO_STAT_ADDR = 12'hF10;

    // Widest register csr_apply serves; callers zero-extend and truncate around it
    localparam int CSR_MAX_W = 64;

    function automatic logic [CSR_MAX_W-1:0] csr_apply(
        input csr_op_e              op,
        input logic [CSR_MAX_W-1:0] old_val,
        input logic [CSR_MAX_W-1:0] wdata
    );
        case (op)
            CSR_WRITE: return wdata;
            CSR_SET:   return old_val | wdata;
            CSR_CLEAR: return old_val & ~wdata;
            default:   return old_val;
        endcase
    endfunction

    function automatic bit ranges_overlap(input int a, input int na, input int b, input int nb);
        return (a < b + nb) && (b < a + na);
    endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - 2-flop input synchroniser with previous-sample change detect
module gpio_sync_edge #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             change
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign dout   = sync_q;
    assign change = (sync_q != prev_q);

endmodule

// File: rtl/csr_gpio_unit.sv
// rtl/csr_gpio_unit.sv - CSR-mapped GPIO inputs/outputs with sticky change flags
// Optional mask register and irq output when CSR_GPIO_IRQ_EN is defined.
module csr_gpio_unit
    import csr_gpio_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          NUM_IN    = 2,
    parameter int          NUM_OUT   = 2,
    parameter logic [11:0] IN_BASE   = GPIO_IN_BASE,
    parameter logic [11:0] OUT_BASE  = GPIO_OUT_BASE,
    parameter logic [11:0] STAT_ADDR = GPIO_STAT_ADDR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [11:0]               csr_addr,
    input  logic                      csr_re,
    input  logic                      csr_we,
    input  logic [1:0]                csr_op,
    input  logic [WIDTH-1:0]          csr_wdata,
    output logic [WIDTH-1:0]          csr_rdata,
    output logic                      csr_rvalid,
    output logic                      csr_err,
    input  logic [NUM_IN*WIDTH-1:0]   gpio_in,
    output logic [NUM_OUT*WIDTH-1:0]  gpio_out
`ifdef CSR_GPIO_IRQ_EN
    ,
    output logic                      irq
`endif
);

`ifdef CSR_GPIO_IRQ_EN
    localparam int STAT_SPAN = 2;
`else
    localparam int STAT_SPAN = 1;
`endif

    if (NUM_IN < 1 || NUM_IN > 16 || NUM_OUT < 1 || NUM_OUT > 16 ||
        WIDTH > CSR_MAX_W || NUM_IN > WIDTH) begin : g_bad_params
        $error("csr_gpio_unit: illegal WIDTH/NUM_IN/NUM_OUT combination");
    end

    if (ranges_overlap(int'(IN_BASE), NUM_IN, int'(OUT_BASE), NUM_OUT) ||
        ranges_overlap(int'(IN_BASE), NUM_IN, int'(STAT_ADDR), STAT_SPAN) ||
        ranges_overlap(int'(OUT_BASE), NUM_OUT, int'(STAT_ADDR), STAT_SPAN)) begin : g_bad_map
        $error("csr_gpio_unit: CSR address ranges overlap");
    end

    csr_op_e op;
    assign op = csr_op_e'(csr_op);

    logic [WIDTH-1:0]   in_sync [NUM_IN];
    logic [NUM_IN-1:0]  in_change;
    logic [WIDTH-1:0]   out_q [NUM_OUT];
    logic [NUM_IN-1:0]  flag_q;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_in
        gpio_sync_edge #(.WIDTH(WIDTH)) u_sync (
            .clk    (clk),
            .rst    (rst),
            .din    (gpio_in[gi*WIDTH +: WIDTH]),
            .dout   (in_sync[gi]),
            .change (in_change[gi])
        );
    end

    for (genvar go = 0; go < NUM_OUT; go++) begin : g_out
        assign gpio_out[go*WIDTH +: WIDTH] = out_q[go];
    end

    logic [WIDTH-1:0]   rd_val;
    logic               rd_hit;
    logic               wr_ok;
    logic [NUM_OUT-1:0] out_sel;
    logic               stat_sel;
    logic [NUM_IN-1:0]  flag_clr;
`ifdef CSR_GPIO_IRQ_EN
    logic               mask_sel;
    logic [WIDTH-1:0]   mask_q;
    logic [WIDTH-1:0]   flag_ext;
`endif

    // Exact-match decode only: every address outside the mapped set is an error
    always_comb begin
        rd_val   = '0;
        rd_hit   = 1'b0;
        out_sel  = '0;
        stat_sel = (csr_addr == STAT_ADDR);
        for (int i = 0; i < NUM_IN; i++) begin
            if (csr_addr == IN_BASE + 12'(i)) begin
                rd_val = in_sync[i];
                rd_hit = 1'b1;
            end
        end
        for (int j = 0; j < NUM_OUT; j++) begin
            if (csr_addr == OUT_BASE + 12'(j)) begin
                rd_val     = out_q[j];
                rd_hit     = 1'b1;
                out_sel[j] = 1'b1;
            end
        end
        if (stat_sel) begin
            rd_val               = '0;
            rd_val[NUM_IN-1:0]   = flag_q;
            rd_hit               = 1'b1;
        end
        wr_ok = (|out_sel) | stat_sel;
`ifdef CSR_GPIO_IRQ_EN
        mask_sel = (csr_addr == STAT_ADDR + 12'd1);
        if (mask_sel) begin
            rd_val = mask_q;
            rd_hit = 1'b1;
        end
        wr_ok = wr_ok | mask_sel;
`endif
    end

    assign flag_clr = (csr_we && stat_sel && (op == CSR_WRITE || op == CSR_CLEAR)) ?
                      csr_wdata[NUM_IN-1:0] : '0;

    // Read path sees pre-edge register values, giving read-before-write on re+we
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csr_rvalid <= 1'b0;
            csr_rdata  <= '0;
            csr_err    <= 1'b0;
            flag_q     <= '0;
        end else begin
            csr_rvalid <= csr_re;
            csr_rdata  <= csr_re ? rd_val : '0;
            csr_err    <= (csr_re && !rd_hit) || (csr_we && !wr_ok);
            flag_q     <= (flag_q & ~flag_clr) | in_change;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NUM_OUT; j++) out_q[j] <= '0;
        end else begin
            for (int j = 0; j < NUM_OUT; j++) begin
                if (csr_we && out_sel[j]) begin
                    out_q[j] <= WIDTH'(csr_apply(op, CSR_MAX_W'(out_q[j]), CSR_MAX_W'(csr_wdata)));
                end
            end
        end
    end

`ifdef CSR_GPIO_IRQ_EN
    always_comb begin
        flag_ext             = '0;
        flag_ext[NUM_IN-1:0] = flag_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q <= '0;
            irq    <= 1'b0;
        end else begin
            if (csr_we && mask_sel) begin
                mask_q <= WIDTH'(csr_apply(op, CSR_MAX_W'(mask_q), CSR_MAX_W'(csr_wdata)));
            end
            irq <= |(flag_ext & mask_q);
        end
    end
`endif

endmodule

// File: tb/tb_csr_gpio_unit.sv
// tb/tb_csr_gpio_unit.sv - directed table-driven bench for csr_gpio_unit
module tb_csr_gpio_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] csr_addr;
    logic        csr_re;
    logic        csr_we;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_rvalid;
    logic        csr_err;
    logic [63:0] gpio_in;
    logic [63:0] gpio_out;
`ifdef CSR_GPIO_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    csr_gpio_unit dut (
        .clk        (clk),
        .rst        (rst),
        .csr_addr   (csr_addr),
        .csr_re     (csr_re),
        .csr_we     (csr_we),
        .csr_op     (csr_op),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .csr_rvalid (csr_rvalid),
        .csr_err    (csr_err),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out)
`ifdef CSR_GPIO_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        re;
        logic        we;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        exp_rv;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] exp_o0;
        logic [31:0] exp_o1;
    } vec_t;

    vec_t vt [19];

    function automatic vec_t mk(input logic re, input logic we, input logic [1:0] op,
                                input logic [11:0] addr, input logic [31:0] wdata,
                                input logic exp_rv, input logic exp_err, input logic [31:0] exp_rd,
                                input logic [31:0] exp_o0, input logic [31:0] exp_o1);
        vec_t v;
        v.re = re; v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
        v.exp_rv = exp_rv; v.exp_err = exp_err; v.exp_rd = exp_rd;
        v.exp_o0 = exp_o0; v.exp_o1 = exp_o1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic re, input logic we, input logic [1:0] op,
                         input logic [11:0] addr, input logic [31:0] wdata);
        csr_re = re; csr_we = we; csr_op = op; csr_addr = addr; csr_wdata = wdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'd0, 12'h000, 32'h0);
    endtask

    initial begin
        // R W op  addr     wdata         rv err rdata         out0          out1
        vt[0]  = mk(1, 0, 0, 12'hF01, 32'h0,        1, 0, 32'hDEADBEEF, 32'h0,  32'h0);
        vt[1]  = mk(1, 0, 0, 12'hF10, 32'h0,        1, 0, 32'h2,        32'h0,  32'h0);
        vt[2]  = mk(0, 1, 0, 12'hF02, 32'hF0,       0, 0, 32'h0,        32'hF0, 32'h0);
        vt[3]  = mk(0, 1, 1, 12'hF02, 32'h0F,       0, 0, 32'h0,        32'hFF, 32'h0);
        vt[4]  = mk(0, 1, 2, 12'hF02, 32'hC0,       0, 0, 32'h0,        32'h3F, 32'h0);
        vt[5]  = mk(0, 1, 3, 12'hF02, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h3F, 32'h0);
        vt[6]  = mk(0, 1, 0, 12'hF03, 32'h1234,     0, 0, 32'h0,        32'h3F, 32'h1234);
        vt[7]  = mk(1, 1, 0, 12'hF03, 32'h5678,     1, 0, 32'h1234,     32'h3F, 32'h5678);
        vt[8]  = mk(1, 0, 0, 12'hF02, 32'h0,        1, 0, 32'h3F,       32'h3F, 32'h5678);
        vt[9]  = mk(0, 1, 0, 12'hF00, 32'h123,      0, 1, 32'h0,        32'h3F, 32'h5678);
        vt[10] = mk(1, 0, 0, 12'hF55, 32'h0,        1, 1, 32'h0,        32'h3F, 32'h5678);
`ifdef CSR_GPIO_IRQ_EN
        vt[11] = mk(1, 0, 0, 12'hF11, 32'h0,        1, 0, 32'h0,        32'h3F, 32'h5678);
`else
        vt[11] = mk(1, 0, 0, 12'hF11, 32'h0,        1, 1, 32'h0,        32'h3F, 32'h5678);
`endif
        vt[12] = mk(0, 1, 1, 12'hF10, 32'hFF,       0, 0, 32'h0,        32'h3F, 32'h5678);
        vt[13] = mk(1, 0, 0, 12'hF10, 32'h0,        1, 0, 32'h2,        32'h3F, 32'h5678);
        vt[14] = mk(0, 1, 0, 12'hF10, 32'h2,        0, 0, 32'h0,        32'h3F, 32'h5678);
        vt[15] = mk(1, 0, 0, 12'hF10, 32'h0,        1, 0, 32'h0,        32'h3F, 32'h5678);
        vt[16] = mk(1, 0, 0, 12'hF04, 32'h0,        1, 1, 32'h0,        32'h3F, 32'h5678);
        vt[17] = mk(1, 0, 0, 12'hF00, 32'h0,        1, 0, 32'h0,        32'h3F, 32'h5678);
        vt[18] = mk(0, 1, 2, 12'hF03, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h3F, 32'h0);

        rst = 1'b1;
        gpio_in = '0;
        idle();
        repeat (2) tick();
        check("reset gpio_out", gpio_out, 64'h0);
        check("reset rvalid", 64'(csr_rvalid), 64'h0);
        check("reset err", 64'(csr_err), 64'h0);
        check("reset rdata", 64'(csr_rdata), 64'h0);
        rst = 1'b0;
        repeat (4) tick();

        drive(1, 0, 0, 12'hF10, 32'h0);
        tick();
        check("idle stat rvalid", 64'(csr_rvalid), 64'h1);
        check("idle stat rdata", 64'(csr_rdata), 64'h0);
        check("idle stat err", 64'(csr_err), 64'h0);
        idle();
        tick();
        check("rvalid drops", 64'(csr_rvalid), 64'h0);

        gpio_in[63:32] = 32'hDEADBEEF;
        repeat (3) tick();

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].re, vt[i].we, vt[i].op, vt[i].addr, vt[i].wdata);
            tick();
            check($sformatf("v%0d rvalid", i), 64'(csr_rvalid), 64'(vt[i].exp_rv));
            check($sformatf("v%0d err", i), 64'(csr_err), 64'(vt[i].exp_err));
            if (vt[i].exp_rv)
                check($sformatf("v%0d rdata", i), 64'(csr_rdata), 64'(vt[i].exp_rd));
            check($sformatf("v%0d gpio_out", i), gpio_out, {vt[i].exp_o1, vt[i].exp_o0});
        end
        idle();

        // Change on ch1 landing in the same cycle as a W1C of its flag
        gpio_in[63:32] = 32'h0;
        repeat (4) tick();
        drive(1, 0, 0, 12'hF10, 32'h0);
        tick();
        check("ch1 fall flag", 64'(csr_rdata), 64'h2);
        idle();
        gpio_in[63:32] = 32'h1;
        tick();
        tick();
        drive(0, 1, 0, 12'hF10, 32'h2);
        tick();
        drive(1, 0, 0, 12'hF10, 32'h0);
        tick();
        check("set beats clear", 64'(csr_rdata), 64'h2);
        drive(0, 1, 2, 12'hF10, 32'h2);
        tick();
        drive(1, 0, 0, 12'hF10, 32'h0);
        tick();
        check("op2 w1c clears", 64'(csr_rdata), 64'h0);
        idle();

`ifdef CSR_GPIO_IRQ_EN
        drive(0, 1, 0, 12'hF11, 32'h1);
        tick();
        drive(1, 0, 0, 12'hF11, 32'h0);
        tick();
        check("mask readback", 64'(csr_rdata), 64'h1);
        idle();
        gpio_in[31:0] = 32'h1;
        repeat (3) tick();
        check("irq before", 64'(irq), 64'h0);
        tick();
        check("irq asserted", 64'(irq), 64'h1);
        drive(0, 1, 0, 12'hF10, 32'h1);
        tick();
        idle();
        check("irq holds at clear edge", 64'(irq), 64'h1);
        tick();
        check("irq cleared", 64'(irq), 64'h0);
`endif

        // Reset in the middle of a read, with ch0 nonzero across release
        gpio_in = {32'h0, 32'h5};
        drive(1, 0, 0, 12'hF10, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("midread rvalid", 64'(csr_rvalid), 64'h0);
        check("midread gpio_out", gpio_out, 64'h0);
        tick();
        idle();
        rst = 1'b0;
        tick();
        check("post-reset rvalid", 64'(csr_rvalid), 64'h0);
        repeat (2) tick();
        drive(1, 0, 0, 12'hF10, 32'h0);
        tick();
        check("release flag", 64'(csr_rdata), 64'h1);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
